// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: issues WORDS word reads to pipelined memory and
// streams returned words into the cache, pulsing the tag write on the last word.
module cache_fill_fsm #(
  parameter int unsigned WORDS  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic [15:0]              memory_data,
  input  logic                     memory_data_valid,
  output logic                     fsm_busy,
  output logic                     memory_en,
  output logic [ADDR_W-1:0]        memory_address,
  output logic                     write_data_array,
  output logic                     write_tag_array,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [15:0]              fill_data
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = IDX_W + 1;
  localparam int unsigned TAG_W = ADDR_W - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state;
  logic [TAG_W-1:0] base;
  logic [CNT_W-1:0] issue_cnt;
  logic [IDX_W-1:0] recv_cnt;

  logic in_fill;
  logic issue;
  logic accept;
  logic last;
  logic unused_offset;

  // Byte offset within the line is discarded; only the line address is kept.
  assign unused_offset = ^miss_address[OFF_W-1:0];

  assign in_fill = (state == FILL);
  assign issue   = in_fill && (issue_cnt < CNT_W'(WORDS));
  // A return is only accepted while a request is outstanding.
  assign accept  = in_fill && memory_data_valid && (CNT_W'(recv_cnt) < issue_cnt);
  assign last    = accept && (recv_cnt == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state     <= FILL;
            base      <= miss_address[ADDR_W-1:OFF_W];
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        FILL: begin
          if (issue)  issue_cnt <= issue_cnt + CNT_W'(1);
          if (accept) recv_cnt  <= recv_cnt + IDX_W'(1);
          if (last)   state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from registers; write strobes are combinational so the cache
  // captures the returned word on the same edge.
  assign fsm_busy         = in_fill;
  assign memory_en        = issue;
  assign memory_address   = in_fill ? {base, issue_cnt[IDX_W-1:0], 1'b0} : '0;
  assign write_data_array = accept;
  assign write_tag_array  = last;
  assign fill_word        = in_fill ? recv_cnt : '0;
  assign fill_data        = in_fill ? memory_data : '0;

endmodule
